// File: rtl/fetch_responder_pkg.sv
// ============================================================================
//  fetch_responder_pkg
//  Shared constants and response type for the fetch responder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_responder_pkg;

    localparam int          C_XLEN      = 64;
    localparam logic [63:0] C_BASE_ADDR = 64'h8000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } fetch_resp_t;

    localparam fetch_resp_t C_RESP_IDLE = '{data: 32'h0, err: 1'b0};

endpackage

`default_nettype wire

// File: rtl/resp_fifo.sv
// ============================================================================
//  resp_fifo
//  Circular FIFO of fetch responses with registered pointers and occupancy.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module resp_fifo
    import fetch_responder_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  fetch_resp_t   push_data_i,
    input  logic          pop_i,
    output fetch_resp_t   head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          w_do_push, w_do_pop;
    fetch_resp_t   mem_q [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_do_pop  = pop_i && (count_q != '0);
    assign w_do_push = push_i && ((count_q != CW'(DEPTH)) || w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (w_do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

`ifndef SYNTHESIS
    // Upstream credits must make a push into a full FIFO impossible.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o && !pop_i));
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_responder.sv
// ============================================================================
//  fetch_responder
//  Memory-side fetch responder: instruction RAM, fixed-latency read pipeline
//  and credit-limited in-order response FIFO, with a backdoor preload port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_responder
    import fetch_responder_pkg::*;
#(
    parameter  int              XLEN       = C_XLEN,
    parameter  logic [XLEN-1:0] BASE_ADDR  = XLEN'(C_BASE_ADDR),
    parameter  int              DEPTH      = 4096,
    parameter  int              LATENCY    = 2,
    parameter  int              RESP_DEPTH = 4,
    localparam int              AW         = $clog2(DEPTH),
    localparam int              OW         = $clog2(RESP_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_addr_valid,
    output logic            fetch_addr_ready,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_data_valid,
    output logic [31:0]     fetch_data,
    output logic            fetch_data_err,
    input  logic            fetch_data_ready,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_waddr,
    input  logic [31:0]     mem_wdata
);

    localparam logic [XLEN-1:0] C_SPAN = XLEN'(DEPTH * 4);

    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic            w_accept;
    logic            w_pop;
    logic [XLEN-1:0] w_off;
    logic            w_legal;
    logic [AW-1:0]   w_index;
    fetch_resp_t     w_rd_resp;
    logic            w_push;
    fetch_resp_t     w_push_resp;
    fetch_resp_t     w_head;
    logic            w_empty;
    logic            w_full;
    logic [OW-1:0]   w_fifo_count;
    logic [31:0]     mem_q [DEPTH];

    assign fetch_addr_ready = (outstanding_q < OW'(RESP_DEPTH));
    assign w_accept         = fetch_addr_valid && fetch_addr_ready;
    assign w_pop            = !w_empty && fetch_data_ready;

    // Modular subtraction makes addresses below the base wrap high and fail the range test.
    assign w_off   = fetch_addr - BASE_ADDR;
    assign w_legal = (fetch_addr[1:0] == 2'b00) && (w_off < C_SPAN);
    assign w_index = w_off[AW+1:2];

    always_comb begin
        w_rd_resp      = C_RESP_IDLE;
        w_rd_resp.data = w_legal ? mem_q[w_index] : 32'h0;
        w_rd_resp.err  = !w_legal;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    // The FIFO entry itself is the last pipeline stage, so LATENCY-1 registers precede it.
    if (LATENCY == 1) begin : g_direct
        assign w_push      = w_accept;
        assign w_push_resp = w_rd_resp;
    end else begin : g_pipe
        logic [LATENCY-2:0] vld_q;
        fetch_resp_t        stage_q [LATENCY-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int i = 0; i < LATENCY - 1; i++) stage_q[i] <= C_RESP_IDLE;
            end else begin
                vld_q[0]   <= w_accept;
                stage_q[0] <= w_rd_resp;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    vld_q[i]   <= vld_q[i-1];
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign w_push      = vld_q[LATENCY-2];
        assign w_push_resp = stage_q[LATENCY-2];
    end

    resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_push_resp),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .empty_o     (w_empty),
        .full_o      (w_full),
        .count_o     (w_fifo_count)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        case ({w_accept, w_pop})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) outstanding_q <= '0;
        else     outstanding_q <= outstanding_d;
    end

    assign fetch_data_valid = !w_empty;
    assign fetch_data       = w_empty ? 32'h0 : w_head.data;
    assign fetch_data_err   = !w_empty && w_head.err;

`ifndef SYNTHESIS
    a_credit_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_accept && !w_pop && (outstanding_q == OW'(RESP_DEPTH))));
    a_credit_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(w_pop && !w_accept && (outstanding_q == '0)));
    a_fifo_within_credit: assert property (@(posedge clk) disable iff (rst)
        w_fifo_count <= outstanding_q);
    a_full_blocks_requests: assert property (@(posedge clk) disable iff (rst)
        w_full |-> !fetch_addr_ready);
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_responder.sv
// ============================================================================
//  tb_fetch_responder
//  Randomised and directed checks of fetch_responder against an in-order model.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_responder;

    localparam int          LAT   = 2;
    localparam int          RD    = 4;
    localparam int          DEPTH = 4096;
    localparam int          PRE   = 64;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_addr_valid = 1'b0;
    logic        fetch_addr_ready;
    logic [63:0] fetch_addr = '0;
    logic        fetch_data_valid;
    logic [31:0] fetch_data;
    logic        fetch_data_err;
    logic        fetch_data_ready = 1'b0;
    logic        mem_we = 1'b0;
    logic [11:0] mem_waddr = '0;
    logic [31:0] mem_wdata = '0;

    always #5 clk = ~clk;

    fetch_responder dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_addr_valid (fetch_addr_valid),
        .fetch_addr_ready (fetch_addr_ready),
        .fetch_addr       (fetch_addr),
        .fetch_data_valid (fetch_data_valid),
        .fetch_data       (fetch_data),
        .fetch_data_err   (fetch_data_err),
        .fetch_data_ready (fetch_data_ready),
        .mem_we           (mem_we),
        .mem_waddr        (mem_waddr),
        .mem_wdata        (mem_wdata)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_accepts = 0;
    logic        m_ev, m_er;

    logic [63:0] b_addr [8];
    logic [31:0] b_data [8];
    logic        b_err  [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t predict(input logic [63:0] a, input int acc);
        exp_t        e;
        logic [63:0] off;
        off   = a - BASE;
        e.acc = acc;
        if (a[1:0] == 2'b00 && off < 64'(DEPTH * 4)) begin
            e.data = model_mem[int'(off >> 2)];
            e.err  = 1'b0;
        end else begin
            e.data = 32'h0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    // Model: a response is visible once LAT cycles have passed since its acceptance and all older ones are gone.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_data_valid", fetch_data_valid, 1'b0);
            check("rst_data_err", fetch_data_err, 1'b0);
            check("rst_addr_ready", fetch_addr_ready, 1'b1);
            exp_q.delete();
        end else begin
            m_ev = (exp_q.size() > 0) && (exp_q[0].acc + LAT <= cyc);
            m_er = (exp_q.size() < RD);
            check("addr_ready", fetch_addr_ready, m_er);
            check("data_valid", fetch_data_valid, m_ev);
            if (m_ev) begin
                check("data_word", fetch_data, exp_q[0].data);
                check("data_err", fetch_data_err, exp_q[0].err);
                if (fetch_data_ready) void'(exp_q.pop_front());
            end
            if (fetch_addr_valid && m_er) begin
                exp_q.push_back(predict(fetch_addr, cyc));
                n_accepts++;
            end
        end
        if (mem_we) model_mem[mem_waddr] = mem_wdata;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back burst from an idle responder with ready held high; literal expectations per response.
    task automatic burst(input int n, input string tag);
        fetch_data_ready = 1'b1;
        for (int k = 0; k < n + 2; k++) begin
            fetch_addr_valid = (k < n);
            if (k < n) fetch_addr = b_addr[k];
            if (k == 1) check({tag, "_first_latency"}, fetch_data_valid, 1'b0);
            if (k >= 2) begin
                check({tag, "_valid"}, fetch_data_valid, 1'b1);
                check({tag, "_data"}, fetch_data, b_data[k-2]);
                check({tag, "_err"}, fetch_data_err, b_err[k-2]);
            end
            step();
        end
        fetch_addr_valid = 1'b0;
        check({tag, "_idle_after"}, fetch_data_valid, 1'b0);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        fetch_addr_valid = 1'b0;
        fetch_data_ready = 1'b1;
        while (exp_q.size() != 0 && t < 50) begin
            step();
            t++;
        end
        check({tag, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] prog [4];
        int          acc0;
        int          t;
        int          r;
        prog = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < PRE; i++) begin
            mem_we    = 1'b1;
            mem_waddr = 12'(i);
            mem_wdata = (i < 4) ? prog[i] : $urandom();
            step();
        end
        mem_we = 1'b0;
        step();

        // Program fetch, in order at full throughput.
        b_addr = '{BASE, BASE + 4, BASE + 8, BASE + 12, 64'h0, 64'h0, 64'h0, 64'h0};
        b_data = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193, 0, 0, 0, 0};
        b_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        burst(4, "prog");

        // Misaligned, below-base and past-end addresses interleaved with legal ones.
        b_addr = '{64'h8000_0000, 64'h8000_0002, 64'h8000_0004, 64'h7FFF_FFFC,
                   64'h8000_0008, 64'h8000_4000, 64'h0, 64'h0};
        b_data = '{32'h00000013, 32'h0, 32'h00100093, 32'h0, 32'h00200113, 32'h0, 0, 0};
        b_err  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        burst(6, "illegal");

        // Credit exhaustion with the consumer stalled.
        acc0 = n_accepts;
        fetch_data_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            fetch_addr_valid = 1'b1;
            fetch_addr       = BASE + 64'(4 * k);
            if (k == 3) check("credit_last_slot", fetch_addr_ready, 1'b1);
            if (k == 4) check("credit_exhausted", fetch_addr_ready, 1'b0);
            step();
        end
        check("credit_accepts", 64'(n_accepts - acc0), 64'd4);
        check("stall_head_stable", fetch_data, 32'h00000013);
        fetch_addr_valid = 1'b0;
        fetch_data_ready = 1'b1;
        step();
        check("credit_return", fetch_addr_ready, 1'b1);
        check("credit_second_word", fetch_data, 32'h00100093);
        drain("credit");

        // Consumer ready toggling every cycle under continuous requests.
        for (int k = 0; k < 40; k++) begin
            fetch_addr_valid = 1'b1;
            fetch_addr       = BASE + 64'(4 * $urandom_range(0, PRE - 1));
            fetch_data_ready = (k % 2 == 0);
            step();
        end
        drain("toggle");

        // Reset with three requests in flight.
        fetch_data_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fetch_addr_valid = 1'b1;
            fetch_addr       = BASE + 64'(4 * (k + 2));
            step();
        end
        fetch_addr_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("async_rst_valid", fetch_data_valid, 1'b0);
        check("async_rst_ready", fetch_addr_ready, 1'b1);
        step();
        step();
        rst = 1'b0;
        check("post_rst_ready", fetch_addr_ready, 1'b1);
        b_addr = '{BASE + 4, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        b_data = '{32'h00100093, 0, 0, 0, 0, 0, 0, 0};
        b_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        burst(1, "post_rst");

        // Random valid/ready stress.
        acc0 = n_accepts;
        t    = 0;
        while (n_accepts - acc0 < 1000 && t < 20000) begin
            fetch_addr_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r == 0)      fetch_addr = BASE - 64'(4 * (1 + $urandom_range(0, 1000)));
            else if (r == 1) fetch_addr = BASE + 64'(DEPTH * 4) + 64'(4 * $urandom_range(0, 1000));
            else if (r == 2) fetch_addr = BASE + 64'(4 * $urandom_range(0, PRE - 1)) + 64'($urandom_range(1, 3));
            else             fetch_addr = BASE + 64'(4 * $urandom_range(0, PRE - 1));
            fetch_data_ready = ($urandom_range(0, 2) != 0);
            step();
            t++;
        end
        check("stress_progress", 64'(n_accepts - acc0 >= 1000), 64'd1);
        drain("stress");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
